// File: rtl/sram_bist.sv
`timescale 1ns/1ps
// Built-in self-test sequencer for a single-port SRAM with registered read data.
// Runs a four-pass write/verify march and reports the first failing address/data.
module sram_bist #(
    parameter int unsigned ADR   = 8,
    parameter int unsigned Data  = 8,
    parameter int unsigned Depth = 256
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    output logic            Busy,
    output logic            Done,
    output logic            Pass,
    output logic [ADR-1:0]  FailAddr,
    output logic [Data-1:0] FailData,
    output logic [Data-1:0] MemDataIn,
    output logic [ADR-1:0]  MemAddr,
    output logic            MemCS,
    output logic            MemWE,
    output logic            MemRD,
    input  logic [Data-1:0] MemDataOut
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR0, S_RD0, S_CHK0, S_WR1, S_RD1, S_CHK1, S_DONE
    } state_t;

    localparam logic [ADR-1:0] LAST = ADR'(Depth - 1);

    function automatic logic [Data-1:0] pat(input logic [ADR-1:0] a);
        logic [Data-1:0] alt;
        alt = '0;
        for (int unsigned i = 0; i < Data; i++) alt[i] = (i % 2 == 0);
        return Data'(a) ^ alt;
    endfunction

    state_t          state_q, state_d;
    logic [ADR-1:0]  addr_q, addr_d;
    logic            pv_q, pv_d;
    logic [ADR-1:0]  p_addr_q, p_addr_d;
    logic [Data-1:0] p_exp_q, p_exp_d;
    logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADR-1:0]  fail_addr_q, fail_addr_d;
    logic [Data-1:0] fail_data_q, fail_data_d;
    logic [Data-1:0] din_q, din_d;
    logic            cs_q, cs_d, we_q, we_d, rd_q, rd_d;
    logic            mismatch, last;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pv_d        = 1'b0;
        p_addr_d    = p_addr_q;
        p_exp_d     = p_exp_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        mismatch    = pv_q && (MemDataOut != p_exp_q);
        last        = (addr_q == LAST);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d     = S_WR0;
                    addr_d      = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_WR0, S_WR1: begin
                if (last) begin
                    state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_RD0, S_RD1: begin
                // Track the read presented this cycle; its data returns next cycle.
                pv_d     = ~mismatch;
                p_addr_d = addr_q;
                p_exp_d  = (state_q == S_RD0) ? pat(addr_q) : ~pat(addr_q);
                if (last) begin
                    state_d = (state_q == S_RD0) ? S_CHK0 : S_CHK1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_CHK0:  state_d = S_WR1;
            S_CHK1:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (mismatch) begin
            state_d     = S_DONE;
            fail_addr_d = p_addr_q;
            fail_data_d = MemDataOut;
        end
        if (state_d == S_DONE && state_q != S_DONE) pass_d = ~mismatch;

        // Outputs are derived from the next state so they register alongside it.
        busy_d = state_d inside {S_WR0, S_RD0, S_CHK0, S_WR1, S_RD1, S_CHK1};
        done_d = (state_d == S_DONE);
        we_d   = state_d inside {S_WR0, S_WR1};
        rd_d   = state_d inside {S_RD0, S_RD1};
        cs_d   = we_d | rd_d;
        if (!cs_d) addr_d = '0;
        din_d  = (state_d == S_WR0) ? pat(addr_d) :
                 (state_d == S_WR1) ? ~pat(addr_d) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pv_q        <= 1'b0;
            p_addr_q    <= '0;
            p_exp_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            din_q       <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pv_q        <= pv_d;
            p_addr_q    <= p_addr_d;
            p_exp_q     <= p_exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            din_q       <= din_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign FailAddr  = fail_addr_q;
    assign FailData  = fail_data_q;
    assign MemDataIn = din_q;
    assign MemAddr   = addr_q;
    assign MemCS     = cs_q;
    assign MemWE     = we_q;
    assign MemRD     = rd_q;

endmodule
